// File: rtl/oddr_serializer.sv
// Multi-lane DDR output serializer.
// One parallel word per lane is accepted through a single-entry HOLD buffer and
// moved into a per-lane shift register. Two bits per lane per clock are then sent
// on Q: the first bit of each pair while the internal clock is high, and the second
// bit while it is low. Q is the XOR of a rising-edge flop and a falling-edge flop,
// so no multiplexer ever sits on the clock path.
//
// Handshake: S_DATA is transferred on an internal rising edge when S_VALID and
// S_READY are both high. S_READY depends only on registered state and RST_N, never
// on S_VALID. A source must hold S_VALID and S_DATA stable until the transfer.
module oddr_serializer #(
  parameter int LANES         = 4,
  parameter int SER_RATIO     = 4,
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit IS_C_INVERTED = 1'b0,
  parameter bit SRVAL         = 1'b0,
  parameter bit IDLE_VAL      = 1'b0
) (
  input  logic                       C,
  input  logic                       RST_N,
  input  logic [LANES*SER_RATIO-1:0] S_DATA,
  input  logic                       S_VALID,
  output logic                       S_READY,
  output logic [LANES-1:0]           Q,
  output logic                       BUSY,
  output logic                       UNDERRUN
);

  localparam int W    = LANES * SER_RATIO;
  localparam int HALF = SER_RATIO / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HALF);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if ((SER_RATIO < 2) || (SER_RATIO > 8) || ((SER_RATIO % 2) != 0) ||
        (LANES < 1) || (LANES > 32)) begin : g_bad_param
      $error("oddr_serializer: SER_RATIO must be even in 2..8 and LANES in 1..32");
    end
  endgenerate

  // All edges used below are edges of the possibly inverted clock.
  logic clk_int;
  assign clk_int = C ^ IS_C_INVERTED;

  logic [W-1:0]     hold_q;
  logic             hold_v;
  logic [W-1:0]     sh_q;
  logic             sh_v;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] rise_q;
  logic [LANES-1:0] fall_q;
  logic [LANES-1:0] out_d2;
  logic             out_data;
  logic             underrun_q;

  logic             load;
  logic             accept;
  logic [W-1:0]     sh_next;
  logic [LANES-1:0] pair_d1;
  logic [LANES-1:0] pair_d2;
  logic [LANES-1:0] next_d1;
  logic [LANES-1:0] next_d2;

  // The shifter takes the held word when empty or when its last pair leaves now.
  assign load    = hold_v & (!sh_v | (cnt == CNT_ONE));
  assign S_READY = RST_N & (!hold_v | load);
  assign accept  = S_VALID & S_READY;

  // Per lane: pick the pair at the send end and shift the lane word by two bits.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SER_RATIO-1:0] lane_w;
      assign lane_w = sh_q[l*SER_RATIO +: SER_RATIO];
      if (LSB_FIRST) begin : g_lsb
        assign pair_d1[l] = lane_w[0];
        assign pair_d2[l] = lane_w[1];
        assign sh_next[l*SER_RATIO +: SER_RATIO] = lane_w >> 2;
      end else begin : g_msb
        assign pair_d1[l] = lane_w[SER_RATIO-1];
        assign pair_d2[l] = lane_w[SER_RATIO-2];
        assign sh_next[l*SER_RATIO +: SER_RATIO] = lane_w << 2;
      end
    end
  endgenerate

  assign next_d1 = sh_v ? pair_d1 : {LANES{IDLE_VAL}};
  assign next_d2 = sh_v ? pair_d2 : {LANES{IDLE_VAL}};

  // HOLD buffer and SHIFT stage: accept, load, shift and pair counting.
  always_ff @(posedge clk_int) begin
    if (!RST_N) begin
      hold_v <= 1'b0;
      sh_v   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        hold_q <= S_DATA;
        hold_v <= 1'b1;
      end else if (load) begin
        hold_v <= 1'b0;
      end
      if (load) begin
        sh_q <= hold_q;
        cnt  <= CNT_LOAD;
        sh_v <= 1'b1;
      end else if (sh_v) begin
        sh_q <= sh_next;
        if (cnt == CNT_ONE) begin
          sh_v <= 1'b0;
          cnt  <= '0;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end
  end

  // OUT stage: rising flop is pre-XORed with the falling flop so Q shows D1 at once.
  always_ff @(posedge clk_int) begin
    if (!RST_N) begin
      rise_q     <= {LANES{SRVAL}} ^ fall_q;
      out_d2     <= {LANES{SRVAL}};
      out_data   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rise_q     <= next_d1 ^ fall_q;
      out_d2     <= next_d2;
      out_data   <= sh_v;
      underrun_q <= sh_v & (cnt == CNT_ONE) & !load;
    end
  end

  // Falling flop flips Q from D1 to D2 for the low half of the clock.
  always_ff @(negedge clk_int) begin
    fall_q <= out_d2 ^ rise_q;
  end

  assign Q        = rise_q ^ fall_q;
  assign BUSY     = hold_v | sh_v | out_data;
  assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Bench for oddr_serializer: a main instance (4 lanes, 4:1, LSB first, SRVAL=1)
// checked cycle by cycle against a word-schedule model, plus a 2:1 MSB-first
// instance on the inverted clock driven with a short directed sequence.
module tb_oddr_serializer;

  localparam int LANES = 4;
  localparam int SR    = 4;
  localparam int HALF  = SR / 2;
  localparam int W     = LANES * SR;
  localparam bit LSB   = 1'b1;
  localparam bit SRV   = 1'b1;
  localparam bit IDLE  = 1'b0;

  // ---------------- clock / reset ----------------
  logic c = 1'b0;
  always #5 c = ~c;

  logic             rst_n;
  logic             s_valid;
  logic [W-1:0]     s_data;
  logic             s_ready;
  logic [LANES-1:0] q;
  logic             busy;
  logic             underrun;

  logic       rst2_n;
  logic       s_valid2;
  logic [1:0] s_data2;
  logic       s_ready2;
  logic [0:0] q2;
  logic       busy2;
  logic       underrun2;

  oddr_serializer #(
    .LANES(LANES), .SER_RATIO(SR), .LSB_FIRST(LSB), .IS_C_INVERTED(1'b0),
    .SRVAL(SRV), .IDLE_VAL(IDLE)
  ) dut (
    .C(c), .RST_N(rst_n), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
    .Q(q), .BUSY(busy), .UNDERRUN(underrun)
  );

  oddr_serializer #(
    .LANES(1), .SER_RATIO(2), .LSB_FIRST(1'b0), .IS_C_INVERTED(1'b1),
    .SRVAL(1'b0), .IDLE_VAL(1'b1)
  ) dut2 (
    .C(c), .RST_N(rst2_n), .S_DATA(s_data2), .S_VALID(s_valid2), .S_READY(s_ready2),
    .Q(q2), .BUSY(busy2), .UNDERRUN(underrun2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard / reference model ----------------
  // Each accepted word is scheduled onto Q: it starts two cycles after acceptance,
  // or right after the previous word if that is later, and lasts HALF cycles.
  logic [W-1:0] exp_q[$];
  int           exp_start[$];
  int           exp_acc[$];
  int           cyc = 0;
  int           last_start = -100;

  logic             obs_ready, obs_busy, obs_und;
  logic [LANES-1:0] obs_hi, obs_lo;
  logic             exp_ready, exp_busy, exp_und;
  logic [LANES-1:0] exp_hi, exp_lo;

  function automatic logic bit_at(input logic [W-1:0] w, input int lane, input int i);
    int idx;
    idx = LSB ? i : SR - 1 - i;
    return w[lane*SR + idx];
  endfunction

  // ---------------- driver ----------------
  // Drives one clock cycle, advances the model and samples Q in both halves.
  task automatic run_cycle(input logic rst, input logic valid, input logic [W-1:0] data,
                           output logic accepted);
    int e;
    int st;
    int p;
    rst_n = rst; s_valid = valid; s_data = data;
    #1;
    obs_ready = s_ready;
    e = cyc + 1;
    exp_ready = rst;
    for (int k = 0; k < exp_q.size(); k++)
      if (exp_acc[k] < e && exp_start[k] - 1 > e) exp_ready = 1'b0;
    accepted = 1'b0;
    @(posedge c);
    cyc = e;
    if (!rst) begin
      exp_q.delete(); exp_start.delete(); exp_acc.delete();
      last_start = -100;
    end else if (valid && exp_ready) begin
      st = (e + 2 > last_start + HALF) ? e + 2 : last_start + HALF;
      exp_q.push_back(data); exp_start.push_back(st); exp_acc.push_back(e);
      last_start = st;
      accepted = 1'b1;
    end
    while (exp_q.size() > 0 && exp_start[0] + HALF - 1 < e) begin
      void'(exp_q.pop_front()); void'(exp_start.pop_front()); void'(exp_acc.pop_front());
    end
    exp_hi = rst ? {LANES{IDLE}} : {LANES{SRV}};
    exp_lo = exp_hi;
    exp_und = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_start[k] <= e && e < exp_start[k] + HALF) begin
        p = e - exp_start[k];
        for (int l = 0; l < LANES; l++) begin
          exp_hi[l] = bit_at(exp_q[k], l, 2*p);
          exp_lo[l] = bit_at(exp_q[k], l, 2*p + 1);
        end
      end
      if (exp_start[k] + HALF - 1 == e) begin
        exp_und = 1'b1;
        for (int j = 0; j < exp_q.size(); j++)
          if (exp_start[j] == e + 1) exp_und = 1'b0;
      end
    end
    exp_busy = rst && (exp_q.size() > 0);
    #1;
    obs_hi = q; obs_busy = busy; obs_und = underrun;
    #5;
    obs_lo = q;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic acc;
    for (int i = 0; i < 5; i++) begin
      run_cycle(i >= 3, 1'b0, W'($urandom), acc);
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL reset cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_single_word();
    logic acc;
    logic [W-1:0] w;
    logic [11:0] q0_seen;
    logic [5:0]  und_seen;
    w = W'($urandom);
    w[3:0] = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, i == 0, (i == 0) ? w : W'($urandom), acc);
      q0_seen = {q0_seen[9:0], obs_hi[0], obs_lo[0]};
      und_seen = {und_seen[4:0], obs_und};
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL single cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
    // Lane 0 from the accept cycle N: idle, idle, (1,1), (0,1), idle, idle.
    checks++;
    if (q0_seen !== 12'b00_00_11_01_00_00) begin
      errors++;
      $display("FAIL single_lane0_seq got %b want %b", q0_seen, 12'b00_00_11_01_00_00);
    end
    // Underrun is seen in the cycle following the edge that latched the last pair.
    checks++;
    if (und_seen !== 6'b000100) begin
      errors++;
      $display("FAIL single_underrun_seq got %b want %b", und_seen, 6'b000100);
    end
  endtask

  task automatic test_streaming();
    logic acc;
    logic [W-1:0] w;
    int sent = 0;
    int und_cnt = 0;
    int n = 0;
    w = W'($urandom);
    while (n < 60 && sent < 8) begin
      run_cycle(1'b1, 1'b1, w, acc);
      n++;
      if (acc) begin sent++; w = W'($urandom); end
      und_cnt += int'(obs_und);
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL stream cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
    checks++;
    if (sent != 8) begin
      errors++;
      $display("FAIL stream_timeout sent %0d words want 8", sent);
    end
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 1'b0, W'($urandom), acc);
      und_cnt += int'(obs_und);
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL stream_drain cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
    checks++;
    if (und_cnt != 1) begin
      errors++;
      $display("FAIL stream_underrun_count got %0d want 1", und_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    logic v = 1'b0;
    logic [W-1:0] w;
    int sent = 0;
    int n = 0;
    w = W'($urandom);
    while (n < 300 && sent < 16) begin
      if (!v) v = ($urandom_range(0, 9) < 7);
      run_cycle(1'b1, v, w, acc);
      n++;
      if (acc) begin sent++; v = 1'b0; w = W'($urandom); end
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL backpressure cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
    checks++;
    if (sent != 16) begin
      errors++;
      $display("FAIL backpressure_timeout sent %0d words want 16", sent);
    end
  endtask

  task automatic test_reset_mid_word();
    logic acc;
    // Words A and B back to back, then one shift cycle so A sits at its last pair,
    // then reset: A and the held B are dropped. After release, word C goes out whole.
    logic rst_seq [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic vld_seq [12] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      run_cycle(rst_seq[i], vld_seq[i], W'($urandom), acc);
      checks++;
      if ({obs_ready, obs_busy, obs_und, obs_hi, obs_lo} !==
          {exp_ready, exp_busy, exp_und, exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d rdy/busy/und/q_hi/q_lo got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc, obs_ready, obs_busy, obs_und, obs_hi, obs_lo,
                 exp_ready, exp_busy, exp_und, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_ratio2_inverted();
    // Internal edges of dut2 are falling edges of c; D1 half is c low, D2 half c high.
    logic [4:0] want [8];
    logic [4:0] got;
    // {s_ready2, busy2, underrun2, q2, stage} is not used; compare fields explicitly.
    rst2_n = 1'b0; s_valid2 = 1'b0; s_data2 = 2'b00;
    repeat (3) @(negedge c);
    #1;
    checks++;
    if ({s_ready2, busy2, underrun2, q2} !== 4'b0000) begin
      errors++;
      $display("FAIL inv_reset rdy/busy/und/q got %b want 0000", {s_ready2, busy2, underrun2, q2});
    end
    rst2_n = 1'b1; s_valid2 = 1'b1; s_data2 = 2'b10;
    #1;
    checks++;
    if (s_ready2 !== 1'b1) begin errors++; $display("FAIL inv_ready0 got %b want 1", s_ready2); end
    @(negedge c); #1;
    s_data2 = 2'b01;
    checks++;
    if (s_ready2 !== 1'b1) begin errors++; $display("FAIL inv_ready1 got %b want 1", s_ready2); end
    @(negedge c); #1;
    s_valid2 = 1'b0;
    checks++;
    if (s_ready2 !== 1'b1) begin errors++; $display("FAIL inv_ready2 got %b want 1", s_ready2); end
    // Half cycles after the third internal edge: word 10 then 01, then idle (1).
    want[0] = 5'b1_1_0_1_0; // ready, busy, underrun, q, unused
    want[1] = 5'b1_1_0_0_0;
    want[2] = 5'b1_1_1_0_0;
    want[3] = 5'b1_1_1_1_0;
    want[4] = 5'b1_0_0_1_0;
    want[5] = 5'b1_0_0_1_0;
    want[6] = 5'b1_0_0_1_0;
    want[7] = 5'b1_0_0_1_0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) @(negedge c); else @(posedge c);
      #1;
      got = {s_ready2, busy2, underrun2, q2, 1'b0};
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL inv_seq half=%0d rdy/busy/und/q got %b want %b", i, got[4:1], want[i][4:1]);
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst2_n = 1'b0; s_valid2 = 1'b0; s_data2 = 2'b00;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_reset_mid_word();
    test_ratio2_inverted();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
